bus_mux_n: RTL
==============

# bus_mux_n

Parametrised single-master to N-slave bus multiplexer with wait-state handshake, registered read-data return, unmapped-address error and slave-timeout abort. Sits between the CPU data port and the peripheral/memory slaves. Decodes the upper address bits into a binary slave index, routes strobes, holds the master until the selected slave accepts, and returns read data and error status one cycle after acceptance.

## Interface
- N_SLAVES, 4, number of slaves, 1..8; elaboration error if > 2**(32-SLAVE_AW)
- SLAVE_AW, 16, slave address width; index = m_addr_i[31:SLAVE_AW]
- TIMEOUT, 16, max stalled cycles before abort; 0 disables timeout
- clk_i  in  1  clock, all logic on rising edge
- reset_n_i  in  1  synchronous, active-low reset
- m_addr_i / m_wdata_i  in  32 / 32  master address, write data
- m_size_i  in  2  access size (byte/half/word), passed through
- m_rd_i / m_wr_i  in  1 / 1  request strobes, mutually exclusive, held until m_ready_o
- m_ready_o  out  1  request accepted this cycle
- m_rdata_o  out  32  read data, valid with m_rvalid_o
- m_rvalid_o  out  1  read response cycle
- m_err_o  out  1  response cycle carries error (unmapped or timeout)
- s_addr_o  out  N_SLAVES*SLAVE_AW  m_addr_i[SLAVE_AW-1:0] replicated
- s_wdata_o  out  N_SLAVES*32  m_wdata_i replicated
- s_size_o  out  N_SLAVES*2  m_size_i replicated
- s_rd_o / s_wr_o  out  N_SLAVES / N_SLAVES  per-slave strobes
- s_ready_i  in  N_SLAVES  per-slave accept
- s_rdata_i  in  N_SLAVES*32  per-slave read data, valid cycle after accept

## Operation
- Hit: index k < N_SLAVES; otherwise miss.
- States: IDLE, WAIT, ABORT.
- IDLE/WAIT with request and hit k: s_rd_o[k]/s_wr_o[k] = request strobe, others 0; m_ready_o = s_ready_i[k]. Accepted → back to IDLE; not accepted → WAIT, counter +1.
- Miss: no slave strobe; m_ready_o=1 same cycle; error response next cycle.
- WAIT with counter == TIMEOUT-1 and no accept → ABORT next cycle; counter saturates, never wraps.
- ABORT: all slave strobes 0, m_ready_o=1 (master request consumed), error response next cycle, → IDLE.
- On every acceptance, register: sel_r=k, rd_r=m_rd_i, err_r=(miss|abort). Counter clears.
- Response cycle: m_rvalid_o=rd_r; m_err_o=err_r; m_rdata_o = err_r ? 0 : s_rdata_i[sel_r]. Writes get m_err_o only.
- Master dropping its request before m_ready_o is a protocol violation; behaviour undefined, no recovery required beyond reset.
- Unselected slave inputs are ignored, including stray s_ready_i.

## Timing
- Zero-wait hit: request and accept at cycle T; response (rvalid/err) at T+1.
- Back-to-back: new request may be presented at T+1; its response at T+2. Sustained throughput one access/cycle.
- Timeout, TIMEOUT=n: request at T0, slave never ready → strobe high T0..T0+n-1, ABORT at T0+n (m_ready_o=1, strobes 0), m_err_o at T0+n+1.
- Slave ready on the same cycle the counter reaches TIMEOUT-1: normal accept wins, no abort.
- Reset (reset_n_i=0): state IDLE, counter 0, sel_r/rd_r/err_r 0; m_rvalid_o=0, m_err_o=0, m_rdata_o=0, m_ready_o=0, all s_rd_o/s_wr_o=0. Reset mid-WAIT/ABORT discards the transaction; no response issued.

## Structure
- Shared package bus_pkg: size encodings (SIZE_B=2'd0, SIZE_H=2'd1, SIZE_W=2'd2), state encoding (IDLE/WAIT/ABORT), index-width function.
- Sub-module bus_mux_wdog: stall counter with clear, increment, expire output; width $clog2(TIMEOUT+1); tied off when TIMEOUT=0.

## Test plan
- Read slave 2 at 0x0002_0010, s_ready_i[2]=1 same cycle, s_rdata_i[2]=0xDEADBEEF → s_rd_o=4'b0100, m_ready_o=1 at T, m_rvalid_o=1 with 0xDEADBEEF, m_err_o=0 at T+1.
- Write slave 1 at 0x0001_0004, ready asserted after 3 wait cycles → s_wr_o[1] high 4 cycles, m_ready_o on 4th, m_err_o=0 next cycle, no rvalid.
- Read unmapped 0x0009_0000 (N_SLAVES=4) → no slave strobe, m_ready_o=1 immediately, next cycle m_rvalid_o=1, m_err_o=1, m_rdata_o=0.
- TIMEOUT=16, write slave 3 never ready → strobe cycles 0-15, ABORT cycle 16 with m_ready_o=1, m_err_o=1 at cycle 17; ready at count 15 instead → normal completion.
- Back-to-back reads slave 0 then slave 1, both zero-wait → responses on consecutive cycles with correct per-slave data.
- reset_n_i low during WAIT → all outputs 0 next cycle, no response after release, next request behaves normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the single-master bus multiplexer: access sizes, FSM
// states and the slave-index width helper.
package bus_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StAbort = 2'd2
  } bus_state_e;

  // Width of a binary slave index; never zero so a single slave still gets a 1-bit select.
  function automatic int unsigned idx_width(input int unsigned n_slaves);
    return (n_slaves <= 1) ? 1 : $clog2(n_slaves);
  endfunction

endpackage

// File: rtl/bus_mux_wdog.sv
// Stall counter for the bus multiplexer: counts un-accepted request cycles,
// saturates at TIMEOUT and flags the last cycle before an abort.
module bus_mux_wdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  if (TIMEOUT == 0) begin : g_off
    assign expire_o = 1'b0;
  end else begin : g_on
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
        cnt_d = '0;
      end else if (inc_i && (cnt_q != CntW'(TIMEOUT))) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign expire_o = (cnt_q == CntW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/bus_mux_n.sv
// Single-master to N-slave bus multiplexer with wait-state handshake, registered
// response, unmapped-address error and slave-timeout abort.
module bus_mux_n
  import bus_pkg::*;
#(
  parameter int unsigned N_SLAVES = 4,
  parameter int unsigned SLAVE_AW = 16,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [31:0]                  m_addr_i,
  input  logic [31:0]                  m_wdata_i,
  input  logic [1:0]                   m_size_i,
  input  logic                         m_rd_i,
  input  logic                         m_wr_i,
  output logic                         m_ready_o,
  output logic [31:0]                  m_rdata_o,
  output logic                         m_rvalid_o,
  output logic                         m_err_o,
  output logic [N_SLAVES*SLAVE_AW-1:0] s_addr_o,
  output logic [N_SLAVES*32-1:0]       s_wdata_o,
  output logic [N_SLAVES*2-1:0]        s_size_o,
  output logic [N_SLAVES-1:0]          s_rd_o,
  output logic [N_SLAVES-1:0]          s_wr_o,
  input  logic [N_SLAVES-1:0]          s_ready_i,
  input  logic [N_SLAVES*32-1:0]       s_rdata_i
);

  localparam int unsigned IdxW = idx_width(N_SLAVES);

  if (SLAVE_AW < 1 || SLAVE_AW > 31) begin : g_bad_aw
    $error("bus_mux_n: SLAVE_AW must be in 1..31");
  end
  if (N_SLAVES < 1 || N_SLAVES > 8 ||
      64'(N_SLAVES) > (64'd1 << (32 - SLAVE_AW))) begin : g_bad_n
    $error("bus_mux_n: N_SLAVES out of range for SLAVE_AW");
  end

  bus_state_e state_q, state_d;

  logic [31:0]         idx_full;
  logic                hit, req;
  logic [IdxW-1:0]     sel, sel_q;
  logic [N_SLAVES-1:0] sel_oh;
  logic                sel_ready;
  logic                rd_q, err_q, err_d, resp_q;
  logic                accept, wd_inc, wd_expire;
  logic [31:0]         sel_rdata;

  assign s_addr_o  = {N_SLAVES{m_addr_i[SLAVE_AW-1:0]}};
  assign s_wdata_o = {N_SLAVES{m_wdata_i}};
  assign s_size_o  = {N_SLAVES{m_size_i}};

  assign idx_full = m_addr_i >> SLAVE_AW;
  assign hit      = (idx_full < N_SLAVES);
  assign sel      = hit ? idx_full[IdxW-1:0] : '0;
  assign req      = m_rd_i | m_wr_i;

  always_comb begin
    sel_oh    = '0;
    sel_ready = 1'b0;
    for (int unsigned k = 0; k < N_SLAVES; k++) begin
      if (hit && (sel == IdxW'(k))) begin
        sel_oh[k] = 1'b1;
        sel_ready = s_ready_i[k];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    s_rd_o    = '0;
    s_wr_o    = '0;
    m_ready_o = 1'b0;
    accept    = 1'b0;
    err_d     = 1'b0;
    wd_inc    = 1'b0;
    unique case (state_q)
      StIdle, StWait: begin
        if (req) begin
          if (!hit) begin
            m_ready_o = 1'b1;
            accept    = 1'b1;
            err_d     = 1'b1;
            state_d   = StIdle;
          end else begin
            s_rd_o = m_rd_i ? sel_oh : '0;
            s_wr_o = m_wr_i ? sel_oh : '0;
            if (sel_ready) begin
              m_ready_o = 1'b1;
              accept    = 1'b1;
              state_d   = StIdle;
            end else if (wd_expire) begin
              state_d = StAbort;
            end else begin
              wd_inc  = 1'b1;
              state_d = StWait;
            end
          end
        end
      end
      StAbort: begin
        // Consume the stalled request; the error goes out next cycle.
        m_ready_o = 1'b1;
        accept    = 1'b1;
        err_d     = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Nothing may be strobed or accepted while reset is held.
    if (!reset_n_i) begin
      state_d   = StIdle;
      s_rd_o    = '0;
      s_wr_o    = '0;
      m_ready_o = 1'b0;
      accept    = 1'b0;
      wd_inc    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      sel_q   <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      resp_q  <= accept;
      if (accept) begin
        sel_q <= sel;
        rd_q  <= m_rd_i;
        err_q <= err_d;
      end
    end
  end

  bus_mux_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clr_i    (accept),
    .inc_i    (wd_inc),
    .expire_o (wd_expire)
  );

  always_comb begin
    sel_rdata = '0;
    for (int unsigned k = 0; k < N_SLAVES; k++) begin
      if (sel_q == IdxW'(k)) begin
        sel_rdata = s_rdata_i[32*k +: 32];
      end
    end
  end

  assign m_rvalid_o = resp_q & rd_q;
  assign m_err_o    = resp_q & err_q;
  assign m_rdata_o  = (resp_q && !err_q) ? sel_rdata : '0;

endmodule
